uart_receiver: RTL

Serial-to-parallel UART receiver for the 8N1 line on `uart_rxd`, running from the 50 MHz board clock. It is the receive-side counterpart of `uart_transmitter` in the same top level. It synchronises and oversamples the line, frames one byte at a time and presents it on a held valid/ack interface to downstream logic such as an echo or command parser. It reports framing and overrun errors.

---
 rtl/uart_receiver.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// Purpose : 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with 16x oversampling.
// Latency : byte presented ~9.56 bit times after the start edge (10.56 with parity).
// Backpr. : held valid/ack; a byte finishing while valid=1 and no ack is dropped and sets overrun.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rxd        raw serial line, idle high, asynchronous to clk
//   data       last accepted byte, LSB = first data bit on the line
//   valid      data holds an unacknowledged byte
//   ack        consumer strobe, clears valid/overrun when valid=1
//   frame_err  one-cycle pulse on bad stop bit (or bad even parity)
//   overrun    sticky: a byte completed while valid=1
//   busy       FSM not in IDLE
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit between data and stop).
module uart_receiver #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;
`endif

    state_t          state;
    state_t          state_n;
    logic            sync1;
    logic            rxs;
    logic [DW-1:0]   div_cnt;
    logic [3:0]      sc;
    logic            v7;
    logic            v8;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    logic            tick;
    logic            vote;
    logic            at9;
    logic            at15;
    logic            start_det;
    logic            shift_en;
    logic            idx_clr;
    logic            accept;
    logic            fe_n;
`ifdef UART_RX_PARITY_EN
    logic            par_bad;
    logic            par_fail;
`endif

    assign tick = (div_cnt == DIV_LAST);
    // Majority of the samples at sc=7 and 8 plus the live sample at sc=9.
    assign vote = (v7 & v8) | (v7 & rxs) | (v8 & rxs);
    assign at9  = tick && (sc == 4'd9);
    assign at15 = tick && (sc == 4'd15);
    assign busy = (state != S_IDLE);

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        accept    = 1'b0;
        fe_n      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_fail  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    start_det = 1'b1;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (at9 && vote) begin
                    state_n = S_IDLE;           // glitch, not a real start bit
                end else if (at15) begin
                    idx_clr = 1'b1;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (at9) begin
                    shift_en = 1'b1;
                end
                if (at15 && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_n = S_PARITY;
`else
                    state_n = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (at9 && (vote != ^shreg)) begin
                    par_fail = 1'b1;
                    fe_n     = 1'b1;
                end
                if (at15) begin
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Decided mid-bit so a back-to-back start edge is not missed.
                if (at9) begin
                    if (vote) begin
`ifdef UART_RX_PARITY_EN
                        accept = !par_bad;
`else
                        accept = 1'b1;
`endif
                        state_n = S_IDLE;
                    end else begin
                        fe_n    = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait for the line to return high so a held-low line is not re-read as starts.
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            div_cnt   <= '0;
            sc        <= 4'd0;
            v7        <= 1'b1;
            v8        <= 1'b1;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            sync1     <= rxd;
            rxs       <= sync1;
            frame_err <= fe_n;

            // Divider free-runs but is realigned to the start edge.
            if (start_det || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (start_det) begin
                sc <= 4'd0;
            end else if (tick) begin
                sc <= sc + 4'd1;
            end

            if (tick && (sc == 4'd7)) begin
                v7 <= rxs;
            end
            if (tick && (sc == 4'd8)) begin
                v8 <= rxs;
            end

            if (shift_en) begin
                shreg <= {vote, shreg[7:1]};
            end

            if (idx_clr) begin
                bit_idx <= 3'd0;
            end else if ((state == S_DATA) && at15) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (accept) begin
                if (!valid) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else if (ack) begin
                    data    <= shreg;
                    overrun <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ack) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_bad <= 1'b0;
        end else if (start_det) begin
            par_bad <= 1'b0;
        end else if (par_fail) begin
            par_bad <= 1'b1;
        end
    end
`endif

endmodule
